// File: rtl/quad_corr_pkg.sv
// Shared definitions for the quad correlator peak scheduler: default sizes,
// controller state encoding and the index-width helper.
package quad_corr_pkg;

  localparam int NCORRS   = 4;
  localparam int CORRBITS = 13;
  localparam int WINBITS  = 8;
  localparam int LATENCY  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Width of an index into n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/quad_corr_max4.sv
// Combinational maximum over N packed unsigned values, reporting the value and
// its position. On equal values the lowest position wins.
module quad_corr_max4
  import quad_corr_pkg::*;
#(
  parameter int N  = NCORRS,
  parameter int W  = CORRBITS,
  parameter int IW = idx_w(N)
) (
  input  logic [N*W-1:0] vals,
  output logic [W-1:0]   max_val,
  output logic [IW-1:0]  max_idx
);

  // Linear scan; strict greater-than keeps the earliest position on ties.
  always_comb begin
    max_val = vals[W-1:0];
    max_idx = '0;
    for (int k = 1; k < N; k++) begin
      if (vals[k*W +: W] > max_val) begin
        max_val = vals[k*W +: W];
        max_idx = IW'(k);
      end
    end
  end

endmodule

// File: rtl/quad_corr_peak_ctrl.sv
// Windowed peak scheduler behind the four-way correlator.
// Delays sample_valid by the correlator latency, scans the correlation outputs
// over a programmed number of qualified cycles and hands the largest value,
// its correlation index and its cycle offset to a valid/ready consumer.
// Build option: QUAD_CORR_PEAK_AUTOREARM_EN - when defined, accepting a
// result restarts the window immediately with the previously latched settings.
module quad_corr_peak_ctrl #(
  parameter int NCORRS   = quad_corr_pkg::NCORRS,
  parameter int CORRBITS = quad_corr_pkg::CORRBITS,
  parameter int WINBITS  = quad_corr_pkg::WINBITS,
  parameter int LATENCY  = quad_corr_pkg::LATENCY,
  parameter int IW       = quad_corr_pkg::idx_w(NCORRS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NCORRS*CORRBITS-1:0] corr_in,
  input  logic                       sample_valid,
  input  logic                       arm,
  input  logic                       abort,
  input  logic [WINBITS-1:0]         window_len,
  input  logic [CORRBITS-1:0]        threshold,
  output logic                       busy,
  output logic                       peak_valid,
  input  logic                       peak_ready,
  output logic [CORRBITS-1:0]        peak_value,
  output logic [IW-1:0]              peak_index,
  output logic [WINBITS-1:0]         peak_offset,
  output logic                       peak_over_thresh
);

  import quad_corr_pkg::*;

  state_e               state_q, state_d;
  logic [LATENCY-1:0]   vld_sr_q, vld_sr_d;
  logic                 vld_d;
  logic [WINBITS-1:0]   len_q, len_d;
  logic [CORRBITS-1:0]  thr_q, thr_d;
  logic [CORRBITS-1:0]  max_q, max_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [WINBITS-1:0]   off_q, off_d;
  logic [WINBITS-1:0]   cnt_q, cnt_d;
  logic [CORRBITS-1:0]  pval_q, pval_d;
  logic [IW-1:0]        pidx_q, pidx_d;
  logic [WINBITS-1:0]   poff_q, poff_d;
  logic                 pover_q, pover_d;

  logic [CORRBITS-1:0]  cand_val;
  logic [IW-1:0]        cand_idx;
  logic                 take;
  logic [CORRBITS-1:0]  fin_val;
  logic [IW-1:0]        fin_idx;
  logic [WINBITS-1:0]   fin_off;

  quad_corr_max4 #(
    .N  (NCORRS),
    .W  (CORRBITS),
    .IW (IW)
  ) u_max (
    .vals    (corr_in),
    .max_val (cand_val),
    .max_idx (cand_idx)
  );

  assign vld_d = vld_sr_q[LATENCY-1];

  // Qualifier delay line so vld_d lines up with the correlator outputs.
  always_comb begin
    vld_sr_d    = vld_sr_q;
    vld_sr_d[0] = sample_valid;
    for (int k = 1; k < LATENCY; k++) begin
      vld_sr_d[k] = vld_sr_q[k-1];
    end
  end

  // Running-max merge; the first qualified cycle of a window always loads.
  always_comb begin
    take    = (cnt_q == '0) || (cand_val > max_q);
    fin_val = take ? cand_val : max_q;
    fin_idx = take ? cand_idx : idx_q;
    fin_off = take ? cnt_q    : off_q;
  end

  // Next-state and datapath updates; abort outranks completion and acceptance.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    thr_d   = thr_q;
    max_d   = max_q;
    idx_d   = idx_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    pval_d  = pval_q;
    pidx_d  = pidx_q;
    poff_d  = poff_q;
    pover_d = pover_q;
    case (state_q)
      IDLE: begin
        if (arm) begin
          len_d   = window_len;
          thr_d   = threshold;
          max_d   = '0;
          idx_d   = '0;
          off_d   = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (abort) begin
          state_d = IDLE;
        end else if (vld_d) begin
          max_d = fin_val;
          idx_d = fin_idx;
          off_d = fin_off;
          cnt_d = cnt_q + WINBITS'(1);
          // A zero length wraps the counter back to zero after 2^WINBITS cycles.
          if (cnt_d == len_q) begin
            pval_d  = fin_val;
            pidx_d  = fin_idx;
            poff_d  = fin_off;
            pover_d = (fin_val >= thr_q);
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (peak_ready) begin
`ifdef QUAD_CORR_PEAK_AUTOREARM_EN
          max_d   = '0;
          idx_d   = '0;
          off_d   = '0;
          cnt_d   = '0;
          state_d = ACCUM;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vld_sr_q <= '0;
      len_q    <= '0;
      thr_q    <= '0;
      max_q    <= '0;
      idx_q    <= '0;
      off_q    <= '0;
      cnt_q    <= '0;
      pval_q   <= '0;
      pidx_q   <= '0;
      poff_q   <= '0;
      pover_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      vld_sr_q <= vld_sr_d;
      len_q    <= len_d;
      thr_q    <= thr_d;
      max_q    <= max_d;
      idx_q    <= idx_d;
      off_q    <= off_d;
      cnt_q    <= cnt_d;
      pval_q   <= pval_d;
      pidx_q   <= pidx_d;
      poff_q   <= poff_d;
      pover_q  <= pover_d;
    end
  end

  assign busy             = (state_q != IDLE);
  assign peak_valid       = (state_q == HOLD);
  assign peak_value       = pval_q;
  assign peak_index       = pidx_q;
  assign peak_offset      = poff_q;
  assign peak_over_thresh = pover_q;

endmodule
